// File: rtl/scope_pkg.sv
// Shared types and constants for the scope capture buffer.
package scope_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StArmed,
    StPost,
    StDone
  } scope_state_e;

  localparam logic [1:0] MODE_FREE   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

  // The unused encoding 3 behaves as normal mode.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_NORMAL : m;
  endfunction

endpackage

// File: rtl/scope_trigger_detect.sv
// Selects the trigger channel, remembers the previous sample and flags a level crossing.
module scope_trigger_detect import scope_pkg::*; #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SAMPLE_W = 12,
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         sample_en,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_data,
  input  logic [CH_W-1:0]              trig_channel,
  input  logic [SAMPLE_W-1:0]          trig_level,
  input  logic                         trig_edge,
  output logic                         hit
);

  logic [SAMPLE_W-1:0] cur;
  logic [SAMPLE_W-1:0] prev_q;
  logic                prev_valid_q;

  always_comb begin
    cur = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (trig_channel == CH_W'(k)) begin
        cur = sample_data[k*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (clear) begin
      prev_valid_q <= 1'b0;
    end else if (sample_en) begin
      prev_q       <= cur;
      prev_valid_q <= 1'b1;
    end
  end

  // Strict inequality on prev keeps a flat signal sitting on the level from re-triggering.
  always_comb begin
    hit = 1'b0;
    if (sample_en && prev_valid_q) begin
      if (trig_edge == EDGE_FALLING) begin
        hit = (prev_q > trig_level) && (cur <= trig_level);
      end else begin
        hit = (prev_q < trig_level) && (cur >= trig_level);
      end
    end
  end

endmodule

// File: rtl/scope_capture.sv
// Circular multi-channel capture buffer with pre-trigger window and frozen-frame readout.
module scope_capture import scope_pkg::*; #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned PRETRIG  = 256,
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned DW   = CHANNELS * SAMPLE_W
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [DW-1:0]       sample_data,
  input  logic [1:0]          mode,
  input  logic                arm,
  input  logic [CH_W-1:0]     trig_channel,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_edge,
  input  logic                frame_ack,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       rd_data,
  output logic                rd_valid,
  output logic                armed,
  output logic                triggered,
  output logic                frame_ready
);

  localparam logic [AW-1:0] PRE_N  = AW'(PRETRIG);
  localparam logic [AW-1:0] POST_N = AW'(DEPTH - PRETRIG - 1);

  scope_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] trig_ptr_q, trig_ptr_d;
  logic [AW-1:0] pre_cnt_q, pre_cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          we, trig_clear, trig_en, hit;
  logic [AW-1:0] rd_phys;

  logic [DW-1:0] mem [DEPTH];

  scope_trigger_detect #(
    .CHANNELS (CHANNELS),
    .SAMPLE_W (SAMPLE_W)
  ) u_trigger_detect (
    .clk_in       (clk_in),
    .reset        (reset),
    .clear        (trig_clear),
    .sample_en    (trig_en),
    .sample_data  (sample_data),
    .trig_channel (trig_channel),
    .trig_level   (trig_level),
    .trig_edge    (trig_edge),
    .hit          (hit)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    trig_ptr_d = trig_ptr_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    mode_d     = mode_q;
    we         = 1'b0;
    trig_clear = 1'b0;
    trig_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arm) begin
          mode_d     = norm_mode(mode);
          pre_cnt_d  = '0;
          trig_clear = 1'b1;
          state_d    = StPre;
        end
      end
      StPre: begin
        if (sample_valid) begin
          we        = 1'b1;
          trig_en   = 1'b1;
          pre_cnt_d = pre_cnt_q + AW'(1);
        end
        // A zero-length window leaves PRE on the first cycle without dropping that sample.
        if ((pre_cnt_q == PRE_N) || (sample_valid && (pre_cnt_q + AW'(1) == PRE_N))) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (sample_valid) begin
          we      = 1'b1;
          trig_en = 1'b1;
          if ((mode_q == MODE_FREE) || hit) begin
            trig_ptr_d = wr_ptr_q;
            post_cnt_d = POST_N;
            state_d    = (POST_N == '0) ? StDone : StPost;
          end
        end
      end
      StPost: begin
        if (sample_valid) begin
          we         = 1'b1;
          post_cnt_d = post_cnt_q - AW'(1);
          if (post_cnt_q == AW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (frame_ack) begin
          if (mode_q == MODE_SINGLE) begin
            state_d = StIdle;
          end else begin
            pre_cnt_d  = '0;
            trig_clear = 1'b1;
            state_d    = StPre;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (we) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      trig_ptr_q  <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      mode_q      <= MODE_FREE;
      armed       <= 1'b0;
      triggered   <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_ptr_q  <= trig_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      mode_q      <= mode_d;
      armed       <= (state_d == StPre) || (state_d == StArmed);
      triggered   <= (state_d == StPost);
      frame_ready <= (state_d == StDone);
    end
  end

  always_ff @(posedge clk_in) begin
    if (we && !reset) begin
      mem[wr_ptr_q] <= sample_data;
    end
  end

  // Logical index 0 is the oldest sample; the subtraction wraps in AW bits.
  assign rd_phys = trig_ptr_q - PRE_N + rd_addr;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en && (state_q == StDone);
      if (rd_en) begin
        rd_data <= mem[rd_phys];
      end
    end
  end

endmodule

// File: tb/tb_scope_capture.sv
// Scoreboard bench for scope_capture: captured frames are checked against the samples sent.
module tb_scope_capture;
  import scope_pkg::*;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned PRETRIG  = 4;
  localparam int unsigned DW       = CHANNELS * SAMPLE_W;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic [1:0]    mode = 2'd0;
  logic          arm = 1'b0;
  logic [1:0]    trig_channel = '0;
  logic [11:0]   trig_level = '0;
  logic          trig_edge = 1'b0;
  logic          frame_ack = 1'b0;
  logic          rd_en = 1'b0;
  logic [3:0]    rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, armed, triggered, frame_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sent[$];

  scope_capture #(
    .CHANNELS (CHANNELS),
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .PRETRIG  (PRETRIG)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .mode         (mode),
    .arm          (arm),
    .trig_channel (trig_channel),
    .trig_level   (trig_level),
    .trig_edge    (trig_edge),
    .frame_ack    (frame_ack),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .armed        (armed),
    .triggered    (triggered),
    .frame_ready  (frame_ready)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int c0, input int c1, input int c2, input int c3);
    return {12'(c3), 12'(c2), 12'(c1), 12'(c0)};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w);
    sample_valid = 1'b1;
    sample_data  = w;
    sent.push_back(w);
    step();
    sample_valid = 1'b0;
  endtask

  task automatic send_junk(input logic [DW-1:0] w);
    sample_valid = 1'b1;
    sample_data  = w;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    sent.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // ti is the index in sent[] of the trigger sample.
  task automatic read_frame(input int ti, input bit ack_last);
    for (int i = 0; i < 16; i++) begin
      rd_en     = 1'b1;
      rd_addr   = 4'(i);
      frame_ack = ack_last && (i == 15);
      exp_q.push_back(sent[ti - 4 + i]);
      step();
    end
    rd_en     = 1'b0;
    frame_ack = 1'b0;
    step();
    step();
    check_eq("rd_drain", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk_in) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) check_eq("rd_valid_unexpected", 64'(rd_valid), 64'd0);
      else check_eq("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    step();
    check_eq("rst_armed", 64'(armed), 64'd0);
    check_eq("rst_triggered", 64'(triggered), 64'd0);
    check_eq("rst_frame_ready", 64'(frame_ready), 64'd0);
    check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
    check_eq("rst_rd_data", 64'(rd_data), 64'd0);
    reset = 1'b0;
    step();

    // Single shot, rising edge on ch0 ramp
    mode = MODE_SINGLE; trig_channel = 2'd0; trig_level = 12'd100; trig_edge = EDGE_RISING;
    do_arm();
    check_eq("s1_armed", 64'(armed), 64'd1);
    for (int k = 0; k < 10; k++) send(mk(10 * k, k, 0, 0));
    check_eq("s1_pre_trig", 64'(triggered), 64'd0);
    send(mk(100, 10, 0, 0));
    check_eq("s1_trig", 64'(triggered), 64'd1);
    check_eq("s1_armed_low", 64'(armed), 64'd0);
    for (int k = 11; k < 22; k++) begin
      send(mk(10 * k, k, 0, 0));
      if (k == 20) check_eq("s1_ready_early", 64'(frame_ready), 64'd0);
    end
    check_eq("s1_ready", 64'(frame_ready), 64'd1);
    check_eq("s1_trig_low", 64'(triggered), 64'd0);
    for (int k = 0; k < 3; k++) send_junk(mk(4095, 4095, 4095, 4095));
    check_eq("s1_ready_hold", 64'(frame_ready), 64'd1);
    read_frame(10, 1'b0);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    check_eq("s1_ack_ready", 64'(frame_ready), 64'd0);
    check_eq("s1_ack_idle", 64'(armed), 64'd0);
    rd_en = 1'b1; rd_addr = 4'd0;
    step();
    rd_en = 1'b0;
    check_eq("s1_rd_idle_valid", 64'(rd_valid), 64'd0);
    step();

    // Normal mode, falling edge on ch2; a ch0 crossing must not count
    mode = MODE_NORMAL; trig_channel = 2'd2; trig_level = 12'h800; trig_edge = EDGE_FALLING;
    do_arm();
    for (int k = 0; k < 4; k++) send(mk(0, k, 12'hFFF, 0));
    send(mk(12'hFFF, 4, 12'hFFF, 0));
    arm = 1'b1;
    send(mk(0, 5, 12'h900, 0));
    arm = 1'b0;
    check_eq("s2_armed", 64'(armed), 64'd1);
    check_eq("s2_no_trig", 64'(triggered), 64'd0);
    send(mk(0, 6, 12'h800, 0));
    check_eq("s2_trig", 64'(triggered), 64'd1);
    frame_ack = 1'b1;
    send(mk(0, 7, 12'h100, 0));
    frame_ack = 1'b0;
    check_eq("s2_ack_in_post", 64'(triggered), 64'd1);
    for (int k = 8; k < 18; k++) send(mk(0, k, 12'h100, 0));
    check_eq("s2_ready", 64'(frame_ready), 64'd1);
    read_frame(6, 1'b1);
    check_eq("s2_rearm", 64'(armed), 64'd1);
    check_eq("s2_rearm_ready", 64'(frame_ready), 64'd0);

    // Continue in normal mode: 37 non-triggering ARMED samples force a wrap
    trig_channel = 2'd0; trig_level = 12'd100; trig_edge = EDGE_RISING;
    sent.delete();
    for (int k = 0; k < 4; k++) send(mk(100, k, 0, 0));
    for (int k = 4; k < 40; k++) send(mk((k % 2 == 1) ? 200 : 100, k, 0, 0));
    send(mk(50, 40, 0, 0));
    check_eq("s3_no_trig", 64'(triggered), 64'd0);
    send(mk(150, 41, 0, 0));
    check_eq("s3_trig", 64'(triggered), 64'd1);
    for (int k = 42; k < 53; k++) send(mk(150, k, 0, 0));
    check_eq("s3_ready", 64'(frame_ready), 64'd1);
    read_frame(41, 1'b0);
    do_reset();

    // Free-run: two frames, second without arm
    mode = MODE_FREE;
    do_arm();
    for (int k = 0; k < 4; k++) send(mk(7, k, 0, 0));
    check_eq("s4_no_trig", 64'(triggered), 64'd0);
    send(mk(7, 4, 0, 0));
    check_eq("s4_trig", 64'(triggered), 64'd1);
    for (int k = 5; k < 16; k++) send(mk(7, k, 0, 0));
    check_eq("s4_ready", 64'(frame_ready), 64'd1);
    read_frame(4, 1'b0);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    check_eq("s4_rearm", 64'(armed), 64'd1);
    sent.delete();
    for (int k = 0; k < 5; k++) send(mk(9, 100 + k, 0, 0));
    check_eq("s4_trig2", 64'(triggered), 64'd1);
    for (int k = 5; k < 16; k++) send(mk(9, 100 + k, 0, 0));
    check_eq("s4_ready2", 64'(frame_ready), 64'd1);
    read_frame(4, 1'b0);
    do_reset();

    // Reset during POST, then a fresh capture
    mode = MODE_SINGLE; trig_channel = 2'd0; trig_level = 12'd100; trig_edge = EDGE_RISING;
    do_arm();
    for (int k = 0; k < 11; k++) send(mk(10 * k, k, 0, 0));
    check_eq("s5_trig", 64'(triggered), 64'd1);
    for (int k = 11; k < 14; k++) send(mk(10 * k, k, 0, 0));
    do_reset();
    check_eq("s5_rst_armed", 64'(armed), 64'd0);
    check_eq("s5_rst_triggered", 64'(triggered), 64'd0);
    check_eq("s5_rst_ready", 64'(frame_ready), 64'd0);
    check_eq("s5_rst_rd_valid", 64'(rd_valid), 64'd0);
    check_eq("s5_rst_rd_data", 64'(rd_data), 64'd0);
    do_arm();
    for (int k = 0; k < 22; k++) begin
      send(mk(5 + 10 * k, k, 1, 2));
      if (k == 9) check_eq("s5_no_trig", 64'(triggered), 64'd0);
    end
    check_eq("s5_ready", 64'(frame_ready), 64'd1);
    read_frame(10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scope_capture.md
# scope_capture

Parametrised multi-channel sample capture buffer for the on-screen ADC scope. It sits between the SPI ADC control block and the 720p pattern/renderer. It records CHANNELS samples per strobe into a circular frame memory, with a configurable pre-trigger window and level/edge triggering on a selected channel. Single-shot, normal and free-run modes are supported. The renderer reads a frozen frame by logical index while capture is halted.

## Interface
- CHANNELS, 4, number of ADC channels packed per sample word
- SAMPLE_W, 12, bits per channel sample (unsigned)
- DEPTH, 1024, samples per frame; power of two, ≥ 8
- PRETRIG, 256, samples kept before the trigger sample; 0 ≤ PRETRIG < DEPTH
- clk_in  in  1  pixel-domain clock; all inputs synchronous to it
- reset  in  1  synchronous, active-high
- sample_valid  in  1  one-cycle strobe; sample_data is valid this cycle
- sample_data  in  CHANNELS*SAMPLE_W  channel k at bits [k*SAMPLE_W +: SAMPLE_W]
- mode  in  2  0 free-run, 1 normal, 2 single, 3 treated as normal
- arm  in  1  start a capture from IDLE
- trig_channel  in  clog2(CHANNELS)  channel compared against trig_level
- trig_level  in  SAMPLE_W  unsigned threshold
- trig_edge  in  1  0 rising, 1 falling
- frame_ack  in  1  renderer is done with the frame and releases it
- rd_en  in  1  read request
- rd_addr  in  clog2(DEPTH)  logical index; 0 is the oldest sample, PRETRIG is the trigger sample
- rd_data  out  CHANNELS*SAMPLE_W  registered read data
- rd_valid  out  1  rd_data valid
- armed  out  1  high in PRE and ARMED
- triggered  out  1  high in POST
- frame_ready  out  1  high in DONE

## Operation
- States: IDLE, PRE, ARMED, POST, DONE.
- IDLE: no writes occur. On arm, latch mode, clear prev_valid, clear pre_cnt, and go to PRE.
- PRE: every sample_valid writes mem[wr_ptr] and increments wr_ptr (mod DEPTH) and pre_cnt. When pre_cnt reaches PRETRIG, go to ARMED; with PRETRIG=0 this happens immediately after entry.
- ARMED: every sample_valid writes circularly. The trigger is evaluated on that same sample.
  - Rising trigger: prev_valid && prev < trig_level && cur ≥ trig_level.
  - Falling trigger: prev_valid && prev > trig_level && cur ≤ trig_level.
  - Free-run mode: the first sample in ARMED is the trigger.
  - On trigger: trig_ptr ← wr_ptr, post_cnt ← DEPTH-PRETRIG-1, go to POST. If DEPTH-PRETRIG-1 = 0, go directly to DONE.
  - prev ← cur on every valid sample in PRE and ARMED; prev_valid is set after the first one.
- POST: every sample_valid writes and decrements post_cnt. The write that takes post_cnt to 0 moves the block to DONE.
- DONE: writes are inhibited and sample_valid is dropped.
  - On frame_ack: modes 0 and 1 re-enter PRE with the same setup as IDLE→PRE, using the latched mode. Mode 2 returns to IDLE.
- Read path: physical address = (trig_ptr − PRETRIG + rd_addr) mod DEPTH, computed in clog2(DEPTH) bits so it wraps naturally.
- rd_data is read with 1-cycle latency. rd_valid = rd_en registered AND (state was DONE). Reads outside DONE return stale memory with rd_valid = 0.
- Ignored inputs: arm outside IDLE, frame_ack outside DONE. mode and trig settings are sampled only at arm or re-arm; trig_channel, trig_level and trig_edge are used live.
- A comparison equal to the level with prev equal to the level does not trigger.

## Timing
- Reset values: state IDLE, wr_ptr 0, trig_ptr 0, counters 0, prev_valid 0.
- Output reset values: rd_data 0, rd_valid 0, armed 0, triggered 0, frame_ready 0. Memory contents are not cleared.
- Reset mid-capture aborts to IDLE on the next edge. The frame in progress is discarded.
- Status outputs are registered state decodes and change the cycle after the causing edge.
- Trigger latency: triggered rises 1 cycle after the triggering sample_valid.
- Capture latency: frame_ready rises 1 cycle after the final POST write.
- frame_ack and rd_en in the same cycle: the read completes with rd_valid = 1, and the state leaves DONE.
- Throughput: one sample per clock is sustained with no drops outside DONE.

## Structure
- The package scope_pkg holds the state enum, the mode encodings (MODE_FREE, MODE_NORMAL, MODE_SINGLE), and the edge constants.
- Sub-module scope_trigger_detect holds the channel mux, the prev register, and the edge comparison. Its output is a one-cycle hit.
- Memory is an inferred simple dual-port RAM: DEPTH × CHANNELS*SAMPLE_W, registered read.

## Test plan
All scenarios use CHANNELS=4, SAMPLE_W=12, DEPTH=16, PRETRIG=4.
- Single, rising edge, trig_level=100, ch0 ramp 0,10,20,…, arm:
  - Trigger on the value 100.
  - frame_ready 1 cycle after the 11th post-trigger sample.
  - rd_addr 0..15 returns 60..210; rd_addr 4 = 100.
- Falling edge on trig_channel=2, trig_level=0x800:
  - ch2 goes 0xFFF,0x900,0x800 → triggers on 0x800.
  - A ch0 crossing in the same window is ignored.
- Free-run mode:
  - After 4 PRE samples the next sample is the trigger.
  - After frame_ack, a second frame completes without arm; rd_addr 4 equals the 5th sample after re-arm.
- Wrap-around: 37 samples in ARMED before the trigger → the logical read order is still contiguous and rd_addr 4 returns the trigger value.
- Reset asserted in POST after 3 samples:
  - All outputs read 0 next cycle, state is IDLE.
  - A subsequent arm captures a full fresh frame.
- Ignored inputs: sample_valid during DONE leaves contents unchanged; arm during ARMED and frame_ack during POST have no effect.
